cpu_datapath: RTL and testbench

Execution datapath downstream of the CPU controller. Consumes the controller's register addresses (DA/AA/BA), function select (FS), operand mux select (MB), result select (resultSource), and write strobes (RW/MW/EOE). Contains a 16x16 register file, an 8-function ALU, a 64x16 data memory, a status-flag register and a halt latch. Returns the result bus D and the A operand to the controller, which uses them for branch and jump targets.

---
 rtl/cpu_datapath_if.sv | 35 +++
 rtl/cpu_datapath.sv | 125 ++++++++++++
 tb/tb_cpu_datapath.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Controller-to-datapath bundle: register addresses, ALU/mux selects and write strobes
// go one way; the result bus, A operand and status come back.
interface cpu_datapath_if #(
  parameter int BUS_SIZE   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_WIDTH   = 6,
  parameter int FS_WIDTH   = 3,
  parameter int RS_WIDTH   = 2
);
  logic [PC_WIDTH-1:0]   PC;
  logic [ADDR_WIDTH-1:0] DA;
  logic [ADDR_WIDTH-1:0] AA;
  logic [ADDR_WIDTH-1:0] BA;
  logic [FS_WIDTH-1:0]   FS;
  logic                  MB;
  logic [RS_WIDTH-1:0]   resultSource;
  logic                  RW;
  logic                  MW;
  logic                  EOE;
  logic [BUS_SIZE-1:0]   D;
  logic [BUS_SIZE-1:0]   A;
  logic [3:0]            flags;
  logic                  halted;
  logic [BUS_SIZE-1:0]   retired;

  modport master (
    output PC, DA, AA, BA, FS, MB, resultSource, RW, MW, EOE,
    input  D, A, flags, halted, retired
  );

  modport slave (
    input  PC, DA, AA, BA, FS, MB, resultSource, RW, MW, EOE,
    output D, A, flags, halted, retired
  );
endinterface

// File: rtl/cpu_datapath.sv
// Execution datapath: register file, ALU, data memory, {Z,N,C,V} flags, halt latch
// and a saturating count of retired writes.
module cpu_datapath #(
  parameter int BUS_SIZE       = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int MEM_ADDR_WIDTH = 6,
  parameter int PC_WIDTH       = 6,
  parameter int FS_WIDTH       = 3,
  parameter int RS_WIDTH       = 2
) (
  input logic           clk,
  input logic           reset,
  cpu_datapath_if.slave bus
);
  localparam int NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam int NUM_WORDS = 2 ** MEM_ADDR_WIDTH;

  logic [BUS_SIZE-1:0] regs [NUM_REGS];
  logic [BUS_SIZE-1:0] mem  [NUM_WORDS];

  logic signed [BUS_SIZE-1:0] a_val;
  logic signed [BUS_SIZE-1:0] b_val;
  logic signed [BUS_SIZE-1:0] alu_res;
  logic        [BUS_SIZE:0]   alu_wide;
  logic                       alu_v;
  logic        [BUS_SIZE-1:0] d_val;
  logic        [BUS_SIZE-1:0] mem_rd;
  logic        [BUS_SIZE-1:0] link_val;
  logic [MEM_ADDR_WIDTH-1:0]  mem_addr;
  logic                       write_ok;

  logic [3:0]          flags_q;
  logic                halted_q;
  logic [BUS_SIZE-1:0] retired_q;

  function automatic logic [BUS_SIZE-1:0] sat_inc(input logic [BUS_SIZE-1:0] x);
    return (x == '1) ? x : x + BUS_SIZE'(1);
  endfunction

  // Operands of equal sign producing a result of the other sign; subtraction passes ~B.
  function automatic logic add_ovf(input logic signed [BUS_SIZE-1:0] x,
                                   input logic signed [BUS_SIZE-1:0] y,
                                   input logic signed [BUS_SIZE-1:0] r);
    return (x[BUS_SIZE-1] == y[BUS_SIZE-1]) && (r[BUS_SIZE-1] != x[BUS_SIZE-1]);
  endfunction

  assign a_val    = (bus.AA == '0) ? '0 : regs[bus.AA];
  assign b_val    = bus.MB ? {{(BUS_SIZE-ADDR_WIDTH){1'b0}}, bus.BA}
                           : ((bus.BA == '0) ? '0 : regs[bus.BA]);
  assign mem_addr = a_val[MEM_ADDR_WIDTH-1:0];
  assign mem_rd   = mem[mem_addr];
  assign link_val = {{(BUS_SIZE-PC_WIDTH){1'b0}}, bus.PC} + BUS_SIZE'(1);
  assign write_ok = ~halted_q;

  always_comb begin
    alu_wide = '0;
    alu_v    = 1'b0;
    case (bus.FS)
      3'b000: begin
        alu_wide = {1'b0, a_val} + {1'b0, b_val};
        alu_v    = add_ovf(a_val, b_val, alu_wide[BUS_SIZE-1:0]);
      end
      3'b001: begin
        alu_wide = {1'b0, a_val} + {1'b0, ~b_val} + (BUS_SIZE+1)'(1);
        alu_v    = add_ovf(a_val, ~b_val, alu_wide[BUS_SIZE-1:0]);
      end
      3'b010:  alu_wide = {1'b0, a_val & b_val};
      3'b011:  alu_wide = {1'b0, a_val | b_val};
      3'b100:  alu_wide = {1'b0, a_val ^ b_val};
      3'b101:  alu_wide = {1'b0, ~a_val};
      3'b110:  alu_wide = {a_val, 1'b0};
      default: alu_wide = {a_val[0], 1'b0, a_val[BUS_SIZE-1:1]};
    endcase
  end

  assign alu_res = alu_wide[BUS_SIZE-1:0];

  always_comb begin
    d_val = alu_res;
    case (bus.resultSource)
      2'b00:   d_val = alu_res;
      2'b01:   d_val = mem_rd;
      2'b10:   d_val = b_val;
      default: d_val = link_val;
    endcase
  end

  // Clock edge: architectural state commits, gated by the halt latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.RW && write_ok && (bus.DA != '0)) begin
      regs[bus.DA] <= d_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (bus.MW && write_ok) begin
      mem[mem_addr] <= b_val;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      if (bus.RW && (bus.resultSource == '0) && write_ok)
        flags_q <= {(alu_res == '0), alu_res[BUS_SIZE-1], alu_wide[BUS_SIZE], alu_v};
      if (bus.EOE)
        halted_q <= 1'b1;
      if ((bus.RW || bus.MW) && write_ok)
        retired_q <= sat_inc(retired_q);
    end
  end

  assign bus.D       = d_val;
  assign bus.A       = a_val;
  assign bus.flags   = flags_q;
  assign bus.halted  = halted_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Scenario bench for cpu_datapath: expectations are queued as stimulus is applied and
// popped against the DUT outputs once they are due.
module tb_cpu_datapath;
  logic clk = 1'b0;
  logic reset;

  cpu_datapath_if bus ();
  cpu_datapath dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [15:0] sb [$];
  logic [15:0] e;
  int compared   = 0;
  int mismatched = 0;
  int m_ret      = 0;
  bit m_halted   = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] fs, input logic [3:0] da, input logic [3:0] aa,
                       input logic [3:0] ba, input logic mb, input logic [1:0] rs,
                       input logic rw, input logic mw, input logic eoe);
    @(negedge clk);
    bus.FS = fs; bus.DA = da; bus.AA = aa; bus.BA = ba; bus.MB = mb;
    bus.resultSource = rs; bus.RW = rw; bus.MW = mw; bus.EOE = eoe;
    if ((rw || mw) && !m_halted && m_ret < 65535) m_ret++;
    if (eoe) m_halted = 1'b1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [2:0] fs, input logic [3:0] da, input logic [3:0] aa,
                      input logic [3:0] ba, input logic mb, input logic [1:0] rs,
                      input logic rw, input logic mw, input logic eoe);
    drive(fs, da, aa, ba, mb, rs, rw, mw, eoe);
    tick();
  endtask

  // Loads an arbitrary 16-bit constant using only 4-bit immediates, shifts and ORs.
  task automatic build_const(input logic [3:0] da, input logic [15:0] val);
    exec(3'b000, da, 4'd0, 4'd0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      if (i != 3)
        for (int k = 0; k < 4; k++) exec(3'b110, da, da, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
      exec(3'b011, da, da, val[i*4 +: 4], 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [19:0] alu_ref(input logic [2:0] fs, input logic [15:0] a,
                                          input logic [15:0] b);
    int ua, ub, sa, sb_i, s;
    logic [15:0] res;
    logic c, v;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb_i = int'($signed(b));
    c = 1'b0; v = 1'b0; res = 16'h0; s = 0;
    case (fs)
      3'd0: begin s = ua + ub; res = s[15:0]; c = (s > 65535);
                  v = ((sa + sb_i) > 32767) || ((sa + sb_i) < -32768); end
      3'd1: begin s = ua - ub; res = s[15:0]; c = (ua >= ub);
                  v = ((sa - sb_i) > 32767) || ((sa - sb_i) < -32768); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = ~a;
      3'd6: begin res = a << 1; c = a[15]; end
      default: begin res = a >> 1; c = a[0]; end
    endcase
    return {(res == 16'h0), res[15], c, v, res};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.PC = '0; bus.DA = '0; bus.AA = '0; bus.BA = '0; bus.FS = '0; bus.MB = 1'b0;
    bus.resultSource = 2'b00; bus.RW = 1'b0; bus.MW = 1'b0; bus.EOE = 1'b0;
    m_ret = 0; m_halted = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000);
    sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0001);
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL reset_flags: got %h want %h", bus.flags, e); end
    e = sb.pop_front(); compared++;
    if ({15'h0, bus.halted} !== e) begin mismatched++; $display("FAIL reset_halted: got %h want %h", bus.halted, e); end
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL reset_retired: got %h want %h", bus.retired, e); end
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL reset_d: got %h want %h", bus.D, e); end
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL reset_a: got %h want %h", bus.A, e); end
    bus.resultSource = 2'b11;
    #1;
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL reset_link: got %h want %h", bus.D, e); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load_imm();
    drive(3'b000, 4'd1, 4'd0, 4'd5, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h0005);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL load_d: got %h want %h", bus.D, e); end
    tick();
    drive(3'b000, 4'd0, 4'd1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0005); sb.push_back(16'h0001);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL load_r1: got %h want %h", bus.A, e); end
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL load_retired: got %h want %h", bus.retired, e); end
  endtask

  task automatic test_add_overflow();
    exec(3'b000, 4'd2, 4'd0, 4'd1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    exec(3'b101, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    exec(3'b111, 4'd1, 4'd1, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 4'd3, 4'd1, 4'd2, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h8000);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL add_d: got %h want %h", bus.D, e); end
    tick();
    sb.push_back(16'h0005);
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL add_flags: got %h want %h", bus.flags, e); end
    drive(3'b000, 4'd0, 4'd3, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h8000);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL add_r3: got %h want %h", bus.A, e); end
  endtask

  task automatic test_compare();
    build_const(4'd5, 16'h0042);
    drive(3'b001, 4'd0, 4'd5, 4'd5, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h0000);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL cmp_d: got %h want %h", bus.D, e); end
    tick();
    sb.push_back(16'h000A);
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL cmp_flags: got %h want %h", bus.flags, e); end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0000);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL cmp_r0: got %h want %h", bus.A, e); end
  endtask

  task automatic test_memory();
    build_const(4'd8, 16'h0041);
    build_const(4'd9, 16'h1234);
    exec(3'b000, 4'd10, 4'd0, 4'd1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 4'd0, 4'd8, 4'd9, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    sb.push_back(16'h0000);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL mem_same_cycle: got %h want %h", bus.D, e); end
    tick();
    drive(3'b000, 4'd0, 4'd10, 4'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h1234);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL mem_wrap_read: got %h want %h", bus.D, e); end
    drive(3'b000, 4'd0, 4'd8, 4'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h1234);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL mem_read_0041: got %h want %h", bus.D, e); end
  endtask

  task automatic test_back_to_back();
    exec(3'b000, 4'd11, 4'd0, 4'd7, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    exec(3'b000, 4'd12, 4'd0, 4'd7, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    drive(3'b110, 4'd11, 4'd11, 4'd11, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    sb.push_back(16'h000E);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL rwmw_d: got %h want %h", bus.D, e); end
    tick();
    sb.push_back(16'(m_ret));
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL rwmw_retired: got %h want %h", bus.retired, e); end
    drive(3'b000, 4'd0, 4'd11, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h000E);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL rwmw_reg: got %h want %h", bus.A, e); end
    drive(3'b000, 4'd0, 4'd12, 4'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0007);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL rwmw_mem_old_b: got %h want %h", bus.D, e); end
  endtask

  task automatic test_link();
    bus.PC = 6'd63;
    drive(3'b000, 4'd7, 4'd0, 4'd0, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h0040);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL link_d: got %h want %h", bus.D, e); end
    tick();
    bus.PC = 6'd0;
    drive(3'b000, 4'd0, 4'd7, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0040);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL link_r7: got %h want %h", bus.A, e); end
  endtask

  task automatic test_flags_hold();
    exec(3'b001, 4'd0, 4'd0, 4'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h0004);
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL borrow_flags: got %h want %h", bus.flags, e); end
    exec(3'b000, 4'd13, 4'd0, 4'd0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    exec(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0004);
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL flags_hold: got %h want %h", bus.flags, e); end
  endtask

  task automatic test_alu();
    logic [15:0] av [8];
    logic [15:0] bv [8];
    logic [19:0] r;
    av[0] = 16'h7FFF; bv[0] = 16'h0001;
    av[1] = 16'h8000; bv[1] = 16'h0001;
    av[2] = 16'hFFFF; bv[2] = 16'hFFFF;
    av[3] = 16'h1234; bv[3] = 16'h5678;
    av[4] = 16'h0000; bv[4] = 16'h8000;
    for (int p = 5; p < 8; p++) begin
      av[p] = 16'($urandom); bv[p] = 16'($urandom);
    end
    for (int p = 0; p < 8; p++) begin
      build_const(4'd12, av[p]);
      build_const(4'd13, bv[p]);
      for (int f = 0; f < 8; f++) begin
        drive(3'(f), 4'd0, 4'd12, 4'd13, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        r = alu_ref(3'(f), av[p], bv[p]);
        sb.push_back(r[15:0]);
        e = sb.pop_front(); compared++;
        if (bus.D !== e) begin
          mismatched++;
          $display("FAIL alu_d fs=%0d a=%h b=%h: got %h want %h", f, av[p], bv[p], bus.D, e);
        end
        tick();
        sb.push_back({12'h0, r[19:16]});
        e = sb.pop_front(); compared++;
        if ({12'h0, bus.flags} !== e) begin
          mismatched++;
          $display("FAIL alu_flags fs=%0d a=%h b=%h: got %h want %h", f, av[p], bv[p], bus.flags, e);
        end
      end
    end
  endtask

  task automatic test_halt();
    exec(3'b001, 4'd0, 4'd0, 4'd1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(3'b000, 4'd7, 4'd0, 4'd9, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    tick();
    sb.push_back(16'h0001); sb.push_back(16'(m_ret));
    e = sb.pop_front(); compared++;
    if ({15'h0, bus.halted} !== e) begin mismatched++; $display("FAIL halt_set: got %h want %h", bus.halted, e); end
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL halt_retired: got %h want %h", bus.retired, e); end
    drive(3'b000, 4'd7, 4'd0, 4'd3, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0);
    sb.push_back(16'h0003);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL halt_d_live: got %h want %h", bus.D, e); end
    tick();
    exec(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    sb.push_back(16'h0004); sb.push_back(16'(m_ret));
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL halt_flags: got %h want %h", bus.flags, e); end
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL halt_retired_hold: got %h want %h", bus.retired, e); end
    drive(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0000);
    e = sb.pop_front(); compared++;
    if (bus.D !== e) begin mismatched++; $display("FAIL halt_mem_blocked: got %h want %h", bus.D, e); end
    drive(3'b000, 4'd0, 4'd7, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    sb.push_back(16'h0009);
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL halt_reg_blocked: got %h want %h", bus.A, e); end
    #2 reset = 1'b0;
    #1;
    m_ret = 0; m_halted = 1'b0;
    sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000); sb.push_back(16'h0000);
    e = sb.pop_front(); compared++;
    if ({15'h0, bus.halted} !== e) begin mismatched++; $display("FAIL async_halted: got %h want %h", bus.halted, e); end
    e = sb.pop_front(); compared++;
    if ({12'h0, bus.flags} !== e) begin mismatched++; $display("FAIL async_flags: got %h want %h", bus.flags, e); end
    e = sb.pop_front(); compared++;
    if (bus.retired !== e) begin mismatched++; $display("FAIL async_retired: got %h want %h", bus.retired, e); end
    e = sb.pop_front(); compared++;
    if (bus.A !== e) begin mismatched++; $display("FAIL async_r7: got %h want %h", bus.A, e); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_load_imm();
    test_add_overflow();
    test_compare();
    test_memory();
    test_back_to_back();
    test_link();
    test_flags_hold();
    test_alu();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
